// File: rtl/receiver.sv
`timescale 1ns/1ps
// receiver: hunts for an alternating 1/0 preamble, then descrambles a fixed-length
// payload with an additive x^7+x^4+1 LFSR. Define RECEIVER_ERROR_COUNT_EN to add ErrorCount.
module receiver #(
  parameter int         PREAMBLE_BITS  = 96,
  parameter int         DATA_BITS      = 256,
  parameter logic [6:0] SCRAMBLER_SEED = 7'h5D
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       InputValid,
  input  logic       Input,
  output logic       Output,
  output logic       OutputValid,
  output logic       Locked,
  output logic       FrameDone,
`ifdef RECEIVER_ERROR_COUNT_EN
  output logic [7:0] ErrorCount,
`endif
  output logic       PreambleError
);

  localparam logic [15:0] PRE_LAST  = 16'(PREAMBLE_BITS - 1);
  localparam logic [15:0] DATA_LAST = 16'(DATA_BITS - 1);

  typedef enum logic [1:0] {HUNT, PREAMBLE, DATA} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [6:0]  s_q, s_d;
  logic        fb;
  logic        out_d, vld_d, done_d, perr_d, lock_d;
  logic        out_p1, vld_p1, done_p1, perr_p1, lock_p1;

  assign fb = s_q[6] ^ s_q[3];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    out_d   = 1'b0;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    if (InputValid) begin
      case (state_q)
        HUNT: begin
          if (Input) begin
            if (PRE_LAST == 16'd0) begin
              state_d = DATA;
              cnt_d   = 16'd0;
              s_d     = SCRAMBLER_SEED;
            end else begin
              state_d = PREAMBLE;
              cnt_d   = 16'd1;
            end
          end
        end
        PREAMBLE: begin
          // Even indices carry 1, odd indices carry 0 (8'hAA, MSB first).
          if (Input == ~cnt_q[0]) begin
            if (cnt_q == PRE_LAST) begin
              state_d = DATA;
              cnt_d   = 16'd0;
              s_d     = SCRAMBLER_SEED;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end else begin
            perr_d  = 1'b1;
            state_d = HUNT;
            cnt_d   = 16'd0;
          end
        end
        DATA: begin
          out_d = Input ^ fb;
          vld_d = 1'b1;
          s_d   = {s_q[5:0], fb};
          if (cnt_q == DATA_LAST) begin
            done_d  = 1'b1;
            state_d = HUNT;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = HUNT;
          cnt_d   = 16'd0;
        end
      endcase
    end
    // Lock covers the whole DATA residency plus the cycle carrying FrameDone.
    lock_d = (state_d == DATA) | done_d;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= HUNT;
      cnt_q   <= 16'd0;
      s_q     <= SCRAMBLER_SEED;
      out_p1  <= 1'b0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      perr_p1 <= 1'b0;
      lock_p1 <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      out_p1  <= out_d;
      vld_p1  <= vld_d;
      done_p1 <= done_d;
      perr_p1 <= perr_d;
      lock_p1 <= lock_d;
    end
  end

  assign Output        = out_p1;
  assign OutputValid   = vld_p1;
  assign FrameDone     = done_p1;
  assign PreambleError = perr_p1;
  assign Locked        = lock_p1;

`ifdef RECEIVER_ERROR_COUNT_EN
  logic [7:0] err_cnt_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      err_cnt_q <= 8'd0;
    end else if (perr_d) begin
      err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  assign ErrorCount = err_cnt_q;
`endif

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter PREAMBLE_BITS, default 96: preamble length in bits (12 bytes of 8'hAA, MSB first).
REQ-002 Parameter DATA_BITS, default 256: payload length in bits per frame, range 1..65535.
REQ-003 Parameter SCRAMBLER_SEED, default 7'h5D: descrambler state loaded at the start of the payload.
REQ-004 Clock  input  1  rising-edge system clock; the only clock.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 InputValid  input  1  Input carries a line bit this cycle.
REQ-007 Input  input  1  serial line bit; idle line is 0.
REQ-008 Output  output  1  descrambled payload bit.
REQ-009 OutputValid  output  1  Output is valid this cycle.
REQ-010 Locked  output  1  high while in DATA state.
REQ-011 FrameDone  output  1  one-cycle pulse with the last payload bit.
REQ-012 PreambleError  output  1  one-cycle pulse on a preamble mismatch.

Function
REQ-013 FSM states: HUNT, PREAMBLE, DATA; 16-bit bit counter; 7-bit descrambler state s[6:0].
REQ-014 State, counter and s advance only on cycles with InputValid=1; InputValid=0 holds everything, OutputValid=0, pulses low.
REQ-015 HUNT: a valid bit of 0 stays in HUNT; a valid bit of 1 is preamble bit 0 -> PREAMBLE with counter=1.
REQ-016 PREAMBLE: expected bit at index k is 1 for even k, 0 for odd k; a match increments the counter.
REQ-017 PREAMBLE mismatch -> PreambleError pulse next cycle, return to HUNT, counter=0; the mismatching bit is not reused as a new preamble start.
REQ-018 Accepting the bit with index PREAMBLE_BITS-1 -> DATA, counter=0, s=SCRAMBLER_SEED.
REQ-019 DATA, per valid bit: fb = s[6]^s[3]; Output = Input^fb; s <= {s[5:0], fb} (x^7+x^4+1).
REQ-020 Output and OutputValid registered: one clock of latency from the valid input bit.
REQ-021 Payload bit DATA_BITS-1 -> FrameDone=1 in the same cycle as its OutputValid, then HUNT.
REQ-022 Next frame may start on the valid bit immediately after the last payload bit.
REQ-023 Locked registered: 1 from the cycle after entering DATA through the cycle FrameDone is high.
REQ-024 Outputs are never X after reset; PreambleError and FrameDone are never high together.

Reset
REQ-025 Reset=1 at a rising edge, in any state including mid-frame: state=HUNT, counter=0, s=SCRAMBLER_SEED, all outputs 0 from the next cycle.
REQ-026 Reset has priority over InputValid; the bit presented in the reset cycle is discarded.

Configuration
REQ-027 Macro RECEIVER_ERROR_COUNT_EN defined: extra output ErrorCount (8 bits), cleared by Reset, +1 per PreambleError, saturating at 8'hFF.
REQ-028 Macro undefined: ErrorCount port and its logic are absent; all other behaviour is identical.

Verification
REQ-029 Reset, then 96 alternating bits starting with 1, then 256 zeros -> Locked rises; first two Output bits are 0,1 (seed 7'h5D); FrameDone on bit 256.
REQ-030 Transmit 256 bits through a reference x^7+x^4+1 scrambler seeded 7'h5D after a valid preamble -> Output equals the original payload bit-exact.
REQ-031 Preamble with bit 40 flipped -> PreambleError for one cycle, Locked stays 0, no OutputValid; ErrorCount=1 when the macro is defined.
REQ-032 Random InputValid gaps (about 50% duty) during preamble and payload -> same Output sequence as the gap-free run; OutputValid only after valid bits.
REQ-033 Reset asserted at payload bit 100 -> outputs 0 next cycle; a following full frame decodes correctly.
REQ-034 Two back-to-back frames with no idle bits -> two FrameDone pulses; both payloads correct.
REQ-035 Macro defined, 300 forced preamble errors -> ErrorCount saturates at 8'hFF.
